// File: rtl/spi_controller_tx.sv
// SPI mode-0 initiator: takes words on a valid/ready handshake and shifts them out MSB first,
// holding cs low across back-to-back words. spi_clk is derived from clk by a half-period counter.
module spi_controller_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_clk,
  output logic              mosi,
  output logic              cs,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [BW-1:0]     r_bit, w_bit;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic              r_spiClk, w_spiClk;
  logic              r_mosi, w_mosi;
  logic              r_cs, w_cs;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_txReady, w_txReady;
  logic              w_cntLast;
  logic              w_accept;

  assign tx_ready = r_txReady;
  assign spi_clk  = r_spiClk;
  assign mosi     = r_mosi;
  assign cs       = r_cs;
  assign busy     = r_busy;
  assign done     = r_done;

  assign w_cntLast = (r_cnt == CNT_LAST);
  assign w_accept  = r_txReady && tx_valid;

  // Every output is registered, so done/tx_ready are raised one cycle early to land
  // exactly on the final LOW cycle of the last bit.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bit     = r_bit;
    w_shift   = r_shift;
    w_spiClk  = r_spiClk;
    w_mosi    = r_mosi;
    w_cs      = r_cs;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_txReady = 1'b0;

    case (r_state)
      IDLE: begin
        w_txReady = 1'b1;
        if (w_accept) begin
          w_shift   = tx_data;
          w_mosi    = tx_data[DATA_W-1];
          w_cs      = 1'b0;
          w_busy    = 1'b1;
          w_txReady = 1'b0;
          w_cnt     = '0;
          w_bit     = BIT_FIRST;
          w_state   = SETUP;
        end
      end
      SETUP: begin
        if (w_cntLast) begin
          w_cnt    = '0;
          w_spiClk = 1'b1;
          w_state  = HIGH;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      HIGH: begin
        if (w_cntLast) begin
          w_cnt    = '0;
          w_spiClk = 1'b0;
          w_shift  = r_shift << 1;
          w_mosi   = w_shift[DATA_W-1];
          w_state  = LOW;
          if (CLK_DIV == 1 && r_bit == '0) begin
            w_done    = 1'b1;
            w_txReady = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      LOW: begin
        if (w_cntLast) begin
          w_cnt = '0;
          if (r_bit != '0) begin
            w_bit    = r_bit - BW'(1);
            w_spiClk = 1'b1;
            w_state  = HIGH;
          end else if (w_accept) begin
            // Burst: cs stays low and the next word starts its setup phase directly.
            w_shift = tx_data;
            w_mosi  = tx_data[DATA_W-1];
            w_bit   = BIT_FIRST;
            w_state = SETUP;
          end else begin
            w_cs    = 1'b1;
            w_mosi  = 1'b0;
            w_state = GAP;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
          if (r_bit == '0 && r_cnt == CNT_LAST - CW'(1)) begin
            w_done    = 1'b1;
            w_txReady = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_cntLast) begin
          w_cnt     = '0;
          w_busy    = 1'b0;
          w_txReady = 1'b1;
          w_state   = IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_spiClk  <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_txReady <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_shift   <= w_shift;
      r_spiClk  <= w_spiClk;
      r_mosi    <= w_mosi;
      r_cs      <= w_cs;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_txReady <= w_txReady;
    end
  end

endmodule
